// File: rtl/axi_rd_burst_bridge.sv
// AXI4 read bridge: splits one long read into 4 KB-safe INCR bursts with credit-managed FWFT buffering.
// Optional m_rresp checking with a sticky s_rerr flag is enabled by defining RD_RRESP_CHECK_EN.
module axi_rd_burst_bridge #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [LEN_W-1:0]  s_arlen,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_rlast,
    output logic              s_done,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast
`ifdef RD_RRESP_CHECK_EN
    ,
    input  logic [1:0]        m_rresp,
    output logic              s_rerr
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CRW   = PTR_W + 1;
    localparam int OSW   = $clog2(MAX_OUTST + 1);
    localparam int CW0   = (LEN_W > 13) ? LEN_W : 13;
    localparam int CW    = (CW0 > CRW) ? CW0 : CRW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem, total, delivered;
    logic [CRW-1:0]    credits;
    logic [OSW-1:0]    outstanding;
    logic              done_q;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CRW-1:0]    count;

    logic              accept, issue, pop, wr_en, last_pop;
    logic [12:0]       page_beats;
    logic [CW-1:0]     cap_w, beats_w;
    logic [8:0]        beats;

    // Beats left before the next 4 KB page; addr is always beat-aligned so the shift is exact.
    always_comb begin
        page_beats = (13'd4096 - {1'b0, addr[11:0]}) >> OFF_W;
        cap_w      = (CW'(page_beats) < CW'(MAX_BURST)) ? CW'(page_beats) : CW'(MAX_BURST);
        beats_w    = (CW'(rem) < cap_w) ? CW'(rem) : cap_w;
        beats      = beats_w[8:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        s_arready = 1'b0;
        m_arvalid = 1'b0;
        case (state)
            IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid && s_arlen != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                // Only raised once it can be honoured, so it never drops before m_arready.
                m_arvalid = (CW'(credits) >= beats_w) && (outstanding < OSW'(MAX_OUTST));
                if (m_arvalid && m_arready && rem == LEN_W'(beats)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = s_arvalid && s_arready;
    assign issue    = m_arvalid && m_arready;
    assign pop      = s_rvalid && s_rready;
    assign wr_en    = m_rvalid && m_rready;
    assign last_pop = pop && s_rlast;

    assign m_araddr = m_arvalid ? addr : '0;
    assign m_arlen  = m_arvalid ? (beats[7:0] - 8'd1) : 8'd0;
    assign m_rready = 1'b1;
    assign s_rvalid = (count != '0);
    assign s_rdata  = mem[rd_ptr];
    assign s_rlast  = s_rvalid && (delivered == total - LEN_W'(1));
    assign s_done   = done_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            rem         <= '0;
            total       <= '0;
            delivered   <= '0;
            credits     <= CRW'(FIFO_DEPTH);
            outstanding <= '0;
            done_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            done_q <= (accept && s_arlen == '0) || last_pop;
            if (accept) begin
                addr      <= s_araddr & ~ADDR_W'(BYTES - 1);
                rem       <= s_arlen;
                total     <= s_arlen;
                delivered <= '0;
            end else begin
                if (issue) begin
                    addr <= addr + (ADDR_W'(beats) << OFF_W);
                    rem  <= rem - LEN_W'(beats);
                end
                if (pop) delivered <= delivered + LEN_W'(1);
            end
            credits     <= credits + CRW'(pop) - (issue ? CRW'(beats) : CRW'(0));
            outstanding <= outstanding + OSW'(issue) - OSW'(m_rvalid && m_rlast);
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CRW'(wr_en) - CRW'(pop);
        end
    end

    // NOTE: the data storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= m_rdata;
    end

`ifdef RD_RRESP_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                             s_rerr <= 1'b0;
        else if (accept)                     s_rerr <= 1'b0;
        else if (m_rvalid && m_rresp != 2'b00) s_rerr <= 1'b1;
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && count == CRW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_axi_rd_burst_bridge.sv
// Directed bench for axi_rd_burst_bridge: DDR responder model plus scoreboards for AR bursts and read beats.
module tb_axi_rd_burst_bridge;

    localparam int DATA_W = 512;

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [DATA_W-1:0] data; logic last; } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_arvalid = 1'b0, s_arready;
    logic [31:0]       s_araddr = '0;
    logic [15:0]       s_arlen = '0;
    logic              s_rvalid, s_rready = 1'b1, s_rlast, s_done;
    logic [DATA_W-1:0] s_rdata;
    logic              m_arvalid, m_arready = 1'b1;
    logic [31:0]       m_araddr;
    logic [7:0]        m_arlen;
    logic              m_rvalid = 1'b0, m_rready, m_rlast = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;

    axi_rd_burst_bridge dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_done(s_done),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast)
    );

    always #5 clk = ~clk;

    ar_t   ar_exp[$];
    ar_t   rq[$];
    beat_t exp_q[$];
    int n_checks = 0, n_fail = 0;
    int n_ar = 0, n_pop = 0, n_done = 0, n_rbeat = 0, cyc = 0;
    int last_pop_cyc = -10, zl_cyc = -10, ar_pop_snap = 0, beat_i = 0;
    int rsp_limit = 1 << 30;
    logic              prev_stall = 1'b0;
    logic [31:0]       prev_addr = '0;
    logic [7:0]        prev_len = '0;
    logic              nx_rvalid = 1'b0, nx_rlast = 1'b0;
    logic [DATA_W-1:0] nx_rdata = '0;

    function automatic logic [DATA_W-1:0] data_of(input logic [31:0] a);
        return {16{a ^ 32'hC3A5_0F1E}};
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor and DDR responder: samples on the falling edge, stages the next R beat.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rq.delete(); exp_q.delete(); ar_exp.delete();
            beat_i = 0; nx_rvalid = 1'b0; nx_rlast = 1'b0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("ar_hold_valid", m_arvalid, 1'b1);
                check("ar_hold_addr", m_araddr, prev_addr);
                check("ar_hold_len", m_arlen, prev_len);
            end
            prev_stall = m_arvalid && !m_arready;
            prev_addr  = m_araddr;
            prev_len   = m_arlen;
            if (m_arvalid && m_arready) begin
                ar_t e;
                n_ar++;
                ar_pop_snap = n_pop;
                check("ar_expected", ar_exp.size() != 0, 1'b1);
                if (ar_exp.size() != 0) begin
                    e = ar_exp.pop_front();
                    check("m_araddr", m_araddr, e.addr);
                    check("m_arlen", m_arlen, e.len);
                end
                rq.push_back('{addr: m_araddr, len: m_arlen});
            end
            if (s_done) begin
                n_done++;
                check("done_timing", (cyc == last_pop_cyc + 1) || (cyc == zl_cyc + 1), 1'b1);
            end
            if (s_rvalid && s_rready) begin
                beat_t b;
                n_pop++;
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("s_rdata", s_rdata, b.data);
                    check("s_rlast", s_rlast, b.last);
                end
                if (s_rlast) last_pop_cyc = cyc;
            end
            if (s_arvalid && s_arready && s_arlen == 16'd0) zl_cyc = cyc;
            if (m_rvalid && m_rready && rq.size() != 0) begin
                n_rbeat++;
                beat_i++;
                if (beat_i == int'(rq[0].len) + 1) begin
                    void'(rq.pop_front());
                    beat_i = 0;
                end
            end
            nx_rvalid = (rq.size() != 0) && (n_rbeat < rsp_limit);
            nx_rlast  = 1'b0;
            if (nx_rvalid) begin
                nx_rdata = data_of(rq[0].addr + 32'(beat_i * 64));
                nx_rlast = (beat_i == int'(rq[0].len));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_rvalid = nx_rvalid;
            m_rdata  = nx_rdata;
            m_rlast  = nx_rlast;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input logic [31:0] addr, input logic [15:0] len);
        logic ok = 1'b0;
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back('{data: data_of((addr & ~32'h3F) + 32'(i * 64)), last: (i == int'(len) - 1)});
        s_arvalid = 1'b1;
        s_araddr  = addr;
        s_arlen   = len;
        for (int i = 0; i < 50; i++) begin
            if (s_arready) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        check("req_accepted", ok, 1'b1);
        step(1);
        s_arvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) step(1);
        check(tag, n_done >= target, 1'b1);
        step(2);
        check({tag, "_beats_left"}, exp_q.size(), 0);
        check({tag, "_bursts_left"}, ar_exp.size(), 0);
    endtask

    initial begin
        int base, pop_base, done_base;
        step(3);
        check("rst_s_arready", s_arready, 1'b1);
        check("rst_m_rready", m_rready, 1'b1);
        check("rst_s_rvalid", s_rvalid, 1'b0);
        check("rst_m_arvalid", m_arvalid, 1'b0);
        check("rst_s_done", s_done, 1'b0);
        check("rst_m_araddr", m_araddr, 32'h0);
        rst = 1'b0;
        step(1);

        // Single burst
        ar_exp.push_back('{addr: 32'h1000, len: 8'd7});
        request(32'h1000, 16'd8);
        wait_done("t1_done", n_done + 1, 100);

        // 4 KB crossing
        ar_exp.push_back('{addr: 32'h1F80, len: 8'd1});
        ar_exp.push_back('{addr: 32'h2000, len: 8'd5});
        request(32'h1F80, 16'd8);
        wait_done("t2_done", n_done + 1, 100);

        // Splitting, then zero length
        ar_exp.push_back('{addr: 32'h000, len: 8'd7});
        ar_exp.push_back('{addr: 32'h200, len: 8'd7});
        ar_exp.push_back('{addr: 32'h400, len: 8'd3});
        request(32'h0, 16'd20);
        wait_done("t3_done", n_done + 1, 150);
        base = n_ar;
        request(32'h0, 16'd0);
        check("zl_done_pulse", s_done, 1'b1);
        check("zl_arready", s_arready, 1'b1);
        check("zl_arvalid", m_arvalid, 1'b0);
        step(4);
        check("zl_no_burst", n_ar - base, 0);
        check("zl_arready_after", s_arready, 1'b1);

        // Consumer backpressure
        s_rready = 1'b0;
        for (int i = 0; i < 8; i++) ar_exp.push_back('{addr: 32'h4000 + 32'(i * 32'h200), len: 8'd7});
        base = n_ar;
        request(32'h4000, 16'd64);
        step(60);
        check("bp_bursts", n_ar - base, 4);
        check("bp_arvalid_low", m_arvalid, 1'b0);
        check("bp_rvalid", s_rvalid, 1'b1);
        pop_base = n_pop;
        s_rready = 1'b1;
        for (int i = 0; i < 100 && n_ar - base < 5; i++) step(1);
        check("bp_resumed", n_ar - base, 5);
        check("bp_resume_pops", ar_pop_snap - pop_base, 8);
        wait_done("t4_done", n_done + 1, 300);

        // AR stall
        m_arready = 1'b0;
        ar_exp.push_back('{addr: 32'h8000, len: 8'd7});
        base = n_ar;
        request(32'h8000, 16'd8);
        for (int i = 0; i < 5; i++) begin
            check("stall_arvalid", m_arvalid, 1'b1);
            check("stall_araddr", m_araddr, 32'h8000);
            check("stall_arlen", m_arlen, 8'd7);
            step(1);
        end
        m_arready = 1'b1;
        wait_done("t5_done", n_done + 1, 100);
        check("stall_one_burst", n_ar - base, 1);

        // Reset while draining with 3 beats buffered
        s_rready  = 1'b0;
        rsp_limit = n_rbeat + 3;
        ar_exp.push_back('{addr: 32'hA000, len: 8'd7});
        request(32'hA000, 16'd8);
        for (int i = 0; i < 50 && n_rbeat < rsp_limit; i++) step(1);
        check("t6_three_beats", n_rbeat, rsp_limit);
        step(2);
        check("t6_buffered", s_rvalid, 1'b1);
        rst = 1'b1;
        step(1);
        check("t6_rst_rvalid", s_rvalid, 1'b0);
        check("t6_rst_arvalid", m_arvalid, 1'b0);
        check("t6_rst_done", s_done, 1'b0);
        check("t6_rst_arready", s_arready, 1'b1);
        rst = 1'b0;
        rsp_limit = 1 << 30;
        done_base = n_done;
        step(3);
        check("t6_no_done", n_done - done_base, 0);
        s_rready = 1'b1;
        ar_exp.push_back('{addr: 32'h0, len: 8'd7});
        request(32'h0, 16'd8);
        wait_done("t6_done", n_done + 1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst_bridge.md
Name: axi_rd_burst_bridge

Overview:
Parametrised successor of the single-burst AXI4 read bridge between the memory interface and DDR. It accepts one long read request (start address plus beat count) and splits it into AXI4 INCR bursts of at most MAX_BURST beats, none crossing a 4 KB boundary. Up to MAX_OUTST bursts may be outstanding. Read data is buffered in an internal FIFO with credit-based issue, so m_rready never has to drop.

Parameters:
DATA_W, 512, data bus width in bits; BYTES = DATA_W/8.
ADDR_W, 32, address width.
LEN_W, 16, width of the slave request length, in beats.
MAX_BURST, 8, maximum beats per AXI burst; power of 2, at most 256.
FIFO_DEPTH, 32, read-data FIFO entries; power of 2, at least MAX_BURST.
MAX_OUTST, 4, maximum issued bursts whose last beat has not yet been received.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_arvalid  in  1  request valid
s_arready  out  1  bridge can accept a request
s_araddr  in  ADDR_W  start byte address; low log2(BYTES) bits are ignored
s_arlen  in  LEN_W  total beats to read
s_rvalid  out  1  read beat valid
s_rready  in  1  consumer accepts beat
s_rdata  out  DATA_W  read beat
s_rlast  out  1  final beat of the whole request
s_done  out  1  one-cycle pulse when the request is complete
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_araddr  out  ADDR_W  AXI burst address
m_arlen  out  8  AXI burst length, encoded as beats minus 1
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready
m_rdata  in  DATA_W  AXI read data
m_rlast  in  1  AXI last beat of a burst

Behaviour:
- Reset, synchronous: all outputs 0 except s_arready = 1 and m_rready = 1. FIFO empty, credits = FIFO_DEPTH, outstanding = 0, FSM in IDLE.
- A reset mid-operation abandons the request, with no s_done pulse. The DDR side is reset in the same cycle.
- Request FSM:
  - IDLE: s_arready = 1. On s_arvalid && s_arready, latch the aligned address, set rem = s_arlen and total = s_arlen, then go to ISSUE. If s_arlen == 0, instead pulse s_done next cycle and stay in IDLE.
  - ISSUE: s_arready = 0. Compute beats = min(rem, MAX_BURST, (4096 - addr[11:0]) / BYTES).
    - Assert m_arvalid only when credits >= beats and outstanding < MAX_OUTST. m_araddr = addr, m_arlen = beats - 1.
    - Once m_arvalid is asserted, m_araddr and m_arlen stay stable until m_arready.
    - On the handshake: addr += beats * BYTES, rem -= beats, credits -= beats, outstanding++.
    - If rem becomes 0, go to DRAIN.
    - First m_arvalid appears 1 cycle after request acceptance; back-to-back bursts are allowed with no gap.
  - DRAIN: when the delivered beat count equals total (final pop), pulse s_done in the next cycle and go to IDLE.
- Data path:
  - m_rready is held at 1 outside reset. Credits guarantee FIFO space.
  - m_rvalid && m_rready writes the FIFO. m_rvalid && m_rlast decrements outstanding.
  - FIFO is first-word-fall-through. A beat is visible on s_rvalid/s_rdata 1 cycle after its write.
  - A pop (s_rvalid && s_rready) returns 1 credit. A simultaneous burst issue and pop updates credits by (+1 - beats) in that cycle.
  - s_rlast = s_rvalid && (delivered == total - 1).
  - s_rdata, s_rvalid and s_rlast stay stable while s_rready = 0.
- Arithmetic: the rem and delivered counters are LEN_W bits. Address increments wrap modulo 2^ADDR_W.
- Simulation assertion: a FIFO write when full is an error.

Optional Feature:
RD_RRESP_CHECK_EN.
- Defined: adds port m_rresp (in, 2 bits) and port s_rerr (out, 1 bit, sticky).
  - s_rerr is set when any beat has m_rresp != 2'b00; data is still forwarded.
  - s_rerr is cleared by rst or by acceptance of a new request.
- Undefined: neither port exists; responses are not checked.

Test Plan:
All scenarios use defaults, BYTES = 64.
1. Single burst: s_araddr = 0x1000, s_arlen = 8 -> one burst, m_araddr = 0x1000, m_arlen = 7. 8 beats delivered in order, s_rlast on beat 8, s_done pulse 1 cycle after the last pop.
2. 4 KB crossing: s_araddr = 0x1F80, s_arlen = 8 -> bursts (0x1F80, m_arlen = 1) then (0x2000, m_arlen = 5). 8 beats total, one s_rlast.
3. Splitting and zero length: s_araddr = 0x0, s_arlen = 20 -> bursts at 0x000 / 0x200 / 0x400 with m_arlen = 7 / 7 / 3. Separately, s_arlen = 0 -> no m_arvalid, s_done pulse, s_arready stays 1.
4. Backpressure: s_rready = 0, s_arlen = 64, m_arready = 1 -> exactly 4 bursts of 8 issued, then m_arvalid stays 0. Raising s_rready resumes issue after 8 pops; all 64 beats delivered, none lost.
5. AR stall: m_arready held 0 for 5 cycles -> m_arvalid = 1 with m_araddr/m_arlen constant for all 5 cycles. Exactly one burst counted on the handshake.
6. Reset mid-operation: rst in DRAIN with 3 beats buffered -> next cycle s_rvalid = 0, m_arvalid = 0, s_done = 0, s_arready = 1. A new request (0x0, 8) then completes normally.
